// File: rtl/eth_tx_framer.sv
// eth_tx_framer
//   Feeds the ethernet100 transmit path. A payload byte stream (valid/ready/last)
//   is packed into 16-bit words and written to the transmit buffer behind the
//   preamble/SFD. The frame is zero-padded to MIN_BYTES and then the
//   transmit-start I/O write is issued (ioaddr 1, data = total byte count).
//
// Ports
//   mclk, mrstn          clock, asynchronous active-low reset
//   s_data/s_valid/
//   s_last/s_ready       payload byte stream, byte taken on s_valid & s_ready
//   tx_busy              transmitter busy status; buffer is left alone while high
//   mcs/mwr/maddr/mdout  transmit buffer write port (low byte goes out first)
//   iocs/iowr/
//   ioaddr/iodout        I/O register write port
//   done                 one-cycle pulse when the frame is handed over
//   err                  one-cycle pulse when an oversize frame is discarded
module eth_tx_framer #(
  parameter int AW        = 10,
  parameter int MIN_BYTES = 60,
  parameter int MAX_BYTES = 1514
) (
  input  logic          mclk,
  input  logic          mrstn,
  input  logic [7:0]    s_data,
  input  logic          s_valid,
  input  logic          s_last,
  output logic          s_ready,
  input  logic          tx_busy,
  output logic          mcs,
  output logic          mwr,
  output logic [AW-1:0] maddr,
  output logic [15:0]   mdout,
  output logic          iocs,
  output logic          iowr,
  output logic [2:0]    ioaddr,
  output logic [15:0]   iodout,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {IDLE, PRE, DATA, PAD, CMD, WAITB, DROP} state_t;

  localparam logic [AW:0]   MAX_N   = (AW+1)'(MAX_BYTES);
  localparam logic [AW-1:0] BASE    = AW'(4);
  localparam logic [AW-1:0] PAD_END = AW'(4 + MIN_BYTES/2 - 1);
  localparam logic [15:0]   MIN_LEN = 16'(MIN_BYTES);

  state_t        state;
  logic [1:0]    pre_cnt;
  logic [AW:0]   cnt;        // index of the next payload byte
  logic [7:0]    held;       // even byte waiting for its odd partner
  logic [AW-1:0] pad_addr;
  logic [15:0]   len;
  logic          seen_busy;

  logic          accept;
  logic [AW-1:0] word_addr;
  logic [15:0]   cnt_len;

  assign accept    = s_valid & s_ready;
  assign word_addr = BASE + cnt[AW:1];
  assign cnt_len   = 16'(cnt) + 16'd1;

  always_ff @(posedge mclk or negedge mrstn) begin
    if (!mrstn) begin
      state     <= IDLE;
      pre_cnt   <= '0;
      cnt       <= '0;
      held      <= '0;
      pad_addr  <= '0;
      len       <= '0;
      seen_busy <= 1'b0;
      s_ready   <= 1'b0;
      mcs       <= 1'b0;
      mwr       <= 1'b0;
      maddr     <= '0;
      mdout     <= '0;
      iocs      <= 1'b0;
      iowr      <= 1'b0;
      ioaddr    <= '0;
      iodout    <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      // strobes are single-cycle; address/data hold their last value
      mcs  <= 1'b0;
      mwr  <= 1'b0;
      iocs <= 1'b0;
      iowr <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          s_ready   <= 1'b0;
          seen_busy <= 1'b0;
          if (s_valid && !tx_busy) begin
            // first preamble word goes out on the same edge we leave IDLE
            state   <= PRE;
            pre_cnt <= 2'd1;
            cnt     <= '0;
            mcs     <= 1'b1;
            mwr     <= 1'b1;
            maddr   <= '0;
            mdout   <= 16'h5555;
          end
        end
        PRE: begin
          mcs     <= 1'b1;
          mwr     <= 1'b1;
          maddr   <= AW'(pre_cnt);
          mdout   <= (pre_cnt == 2'd3) ? 16'h55D5 : 16'h5555;
          pre_cnt <= pre_cnt + 2'd1;
          if (pre_cnt == 2'd3) begin
            state   <= DATA;
            s_ready <= 1'b1;
          end
        end
        DATA: begin
          if (accept) begin
            cnt <= cnt + 1'b1;
            if (cnt == MAX_N) begin
              // one byte past the maximum: abandon the frame
              err <= 1'b1;
              if (s_last) begin
                s_ready <= 1'b0;
                state   <= IDLE;
              end else begin
                state <= DROP;
              end
            end else begin
              held <= s_data;
              if (cnt[0] || s_last) begin
                mcs   <= 1'b1;
                mwr   <= 1'b1;
                maddr <= word_addr;
                mdout <= cnt[0] ? {s_data, held} : {8'h00, s_data};
              end
              if (s_last) begin
                s_ready  <= 1'b0;
                len      <= cnt_len;
                pad_addr <= word_addr + AW'(1);
                state    <= (cnt_len < MIN_LEN) ? PAD : CMD;
              end
            end
          end
        end
        PAD: begin
          // an odd length just under the minimum may already reach PAD_END
          if (pad_addr <= PAD_END) begin
            mcs      <= 1'b1;
            mwr      <= 1'b1;
            maddr    <= pad_addr;
            mdout    <= 16'h0000;
            pad_addr <= pad_addr + AW'(1);
            if (pad_addr == PAD_END) begin
              len   <= MIN_LEN;
              state <= CMD;
            end
          end else begin
            len   <= MIN_LEN;
            state <= CMD;
          end
        end
        CMD: begin
          iocs   <= 1'b1;
          iowr   <= 1'b1;
          ioaddr <= 3'd1;
          iodout <= 16'd8 + len;
          done   <= 1'b1;
          state  <= WAITB;
        end
        WAITB: begin
          // status bit may lag the command; wait for a full busy period
          if (tx_busy) begin
            seen_busy <= 1'b1;
          end else if (seen_busy) begin
            state <= IDLE;
          end
        end
        DROP: begin
          if (accept && s_last) begin
            s_ready <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_framer.sv
// tb_eth_tx_framer
//   Bench for eth_tx_framer. Two instances share the stimulus: dut_a
//   (MIN_BYTES=16, MAX_BYTES=20) and dut_b (MIN_BYTES=60, MAX_BYTES=1514);
//   sel chooses which one receives s_valid and which one is observed.
//   Expected buffer words and I/O commands are queued as stimulus is driven
//   and compared in order as the selected instance writes them.
module tb_eth_tx_framer;

  logic       mclk = 1'b0;
  logic       mrstn;
  logic [7:0] s_data;
  logic       s_valid, s_last, tx_busy, sel;

  always #5 mclk = ~mclk;

  logic        va, vb;
  assign va = s_valid & ~sel;
  assign vb = s_valid & sel;

  logic        a_ready, a_mcs, a_mwr, a_iocs, a_iowr, a_done, a_err;
  logic [9:0]  a_maddr;
  logic [15:0] a_mdout, a_iodout;
  logic [2:0]  a_ioaddr;
  logic        b_ready, b_mcs, b_mwr, b_iocs, b_iowr, b_done, b_err;
  logic [9:0]  b_maddr;
  logic [15:0] b_mdout, b_iodout;
  logic [2:0]  b_ioaddr;

  eth_tx_framer #(.AW(10), .MIN_BYTES(16), .MAX_BYTES(20)) dut_a (
    .mclk(mclk), .mrstn(mrstn), .s_data(s_data), .s_valid(va), .s_last(s_last),
    .s_ready(a_ready), .tx_busy(tx_busy), .mcs(a_mcs), .mwr(a_mwr), .maddr(a_maddr),
    .mdout(a_mdout), .iocs(a_iocs), .iowr(a_iowr), .ioaddr(a_ioaddr), .iodout(a_iodout),
    .done(a_done), .err(a_err));

  eth_tx_framer #(.AW(10), .MIN_BYTES(60), .MAX_BYTES(1514)) dut_b (
    .mclk(mclk), .mrstn(mrstn), .s_data(s_data), .s_valid(vb), .s_last(s_last),
    .s_ready(b_ready), .tx_busy(tx_busy), .mcs(b_mcs), .mwr(b_mwr), .maddr(b_maddr),
    .mdout(b_mdout), .iocs(b_iocs), .iowr(b_iowr), .ioaddr(b_ioaddr), .iodout(b_iodout),
    .done(b_done), .err(b_err));

  logic        w_ready, w_mcs, w_mwr, w_iocs, w_iowr, w_done, w_err;
  logic [9:0]  w_maddr;
  logic [15:0] w_mdout, w_iodout;
  logic [2:0]  w_ioaddr;
  assign w_ready  = sel ? b_ready  : a_ready;
  assign w_mcs    = sel ? b_mcs    : a_mcs;
  assign w_mwr    = sel ? b_mwr    : a_mwr;
  assign w_maddr  = sel ? b_maddr  : a_maddr;
  assign w_mdout  = sel ? b_mdout  : a_mdout;
  assign w_iocs   = sel ? b_iocs   : a_iocs;
  assign w_iowr   = sel ? b_iowr   : a_iowr;
  assign w_ioaddr = sel ? b_ioaddr : a_ioaddr;
  assign w_iodout = sel ? b_iodout : a_iodout;
  assign w_done   = sel ? b_done   : a_done;
  assign w_err    = sel ? b_err    : a_err;

  logic [25:0] exp_w[$];
  logic [18:0] exp_c[$];
  logic [25:0] e_w;
  logic [18:0] e_c;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int mcs_cnt  = 0;
  int both_cnt = 0;
  int done_bad = 0;
  int acc_cnt  = 0;
  int err_at   = 0;

  always @(posedge mclk) begin
    if (s_valid && w_ready) acc_cnt <= acc_cnt + 1;
  end

  // scoreboard: compare every buffer write and I/O write against the queues
  always @(negedge mclk) begin
    if (w_mcs) mcs_cnt++;
    if (w_mcs && w_iocs) both_cnt++;
    if (w_done) begin
      done_cnt++;
      if (!(w_iocs && w_iowr)) done_bad++;
    end
    if (w_err) begin
      err_cnt++;
      err_at = acc_cnt;
    end
    if (w_mcs && w_mwr) begin
      n_checks++;
      if (exp_w.size() == 0) begin
        n_fail++;
        $display("FAIL buf_write: got addr %0d data %h, required no write", w_maddr, w_mdout);
      end else begin
        e_w = exp_w.pop_front();
        if ({w_maddr, w_mdout} !== e_w) begin
          n_fail++;
          $display("FAIL buf_write: got addr %0d data %h, required addr %0d data %h",
                   w_maddr, w_mdout, e_w[25:16], e_w[15:0]);
        end
      end
    end
    if (w_iocs && w_iowr) begin
      n_checks++;
      if (exp_c.size() == 0) begin
        n_fail++;
        $display("FAIL io_write: got ioaddr %0d data %0d, required no command", w_ioaddr, w_iodout);
      end else begin
        e_c = exp_c.pop_front();
        if ({w_ioaddr, w_iodout} !== e_c) begin
          n_fail++;
          $display("FAIL io_write: got ioaddr %0d data %0d, required ioaddr %0d data %0d",
                   w_ioaddr, w_iodout, e_c[18:16], e_c[15:0]);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge mclk);
  endtask

  // Drive one frame of bytes first, first+1, ... and queue what it must produce.
  task automatic send_frame(input int len, input logic [7:0] first, input bit gaps,
                            input int minb, input int maxb, input string name);
    logic [7:0] d;
    logic [7:0] prev;
    int         t;
    int         plen;
    exp_w.push_back({10'd0, 16'h5555});
    exp_w.push_back({10'd1, 16'h5555});
    exp_w.push_back({10'd2, 16'h5555});
    exp_w.push_back({10'd3, 16'h55D5});
    prev = 8'h00;
    for (int i = 0; i < len; i++) begin
      d = first + 8'(i);
      @(negedge mclk);
      s_valid = 1'b1;
      s_data  = d;
      s_last  = (i == len - 1);
      t = 0;
      while (!w_ready && t < 200) begin
        @(negedge mclk);
        t++;
      end
      if (!w_ready) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s_handshake: byte %0d not accepted after %0d cycles, required acceptance",
                 name, i, t);
        s_valid = 1'b0;
        s_last  = 1'b0;
        return;
      end
      @(posedge mclk);
      if (i < maxb) begin
        if (i % 2 == 1) exp_w.push_back({10'(4 + i/2), d, prev});
        else if (i == len - 1) exp_w.push_back({10'(4 + i/2), 8'h00, d});
      end
      prev = d;
      if (gaps) begin
        @(negedge mclk);
        s_valid = 1'b0;
        s_last  = 1'b0;
      end
    end
    if (!gaps) begin
      @(negedge mclk);
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
    if (len <= maxb) begin
      plen = len;
      if (len < minb) begin
        for (int a = 4 + (len + 1)/2; a <= 4 + minb/2 - 1; a++) exp_w.push_back({10'(a), 16'h0000});
        plen = minb;
      end
      exp_c.push_back({3'd1, 16'(8 + plen)});
    end
  endtask

  task automatic wait_done(input int target, input string name);
    int t = 0;
    while (done_cnt < target && t < 300) begin
      @(negedge mclk);
      #1;
      t++;
    end
    n_checks++;
    if (done_cnt != target) begin
      n_fail++;
      $display("FAIL %s_done: got %0d done pulses, required %0d", name, done_cnt, target);
    end
  endtask

  task automatic pulse_busy();
    @(negedge mclk);
    tx_busy = 1'b1;
    cycles(3);
    tx_busy = 1'b0;
    cycles(3);
    #1;
  endtask

  task automatic test_reset();
    int m0;
    sel = 1'b0; s_valid = 1'b1; s_data = 8'h11; s_last = 1'b0; tx_busy = 1'b0;
    mrstn = 1'b0;
    cycles(3);
    #1;
    n_checks++;
    if ({a_ready, a_mcs, a_mwr, a_maddr, a_mdout, a_iocs, a_iowr, a_ioaddr, a_iodout, a_done, a_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_a: got ready %b mcs %b maddr %h mdout %h iocs %b iodout %h, required all 0",
               a_ready, a_mcs, a_maddr, a_mdout, a_iocs, a_iodout);
    end
    n_checks++;
    if ({b_ready, b_mcs, b_mwr, b_maddr, b_mdout, b_iocs, b_iowr, b_ioaddr, b_iodout, b_done, b_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_b: got ready %b mcs %b maddr %h mdout %h iocs %b iodout %h, required all 0",
               b_ready, b_mcs, b_maddr, b_mdout, b_iocs, b_iodout);
    end
    exp_w.push_back({10'd0, 16'h5555});
    mrstn = 1'b1;
    @(negedge mclk);
    #1;
    n_checks++;
    if ({a_mcs, a_mwr, a_maddr, a_mdout} !== {1'b1, 1'b1, 10'd0, 16'h5555}) begin
      n_fail++;
      $display("FAIL reset_pre_start: got mcs %b mwr %b addr %0d data %h, required mcs 1 mwr 1 addr 0 data 5555",
               a_mcs, a_mwr, a_maddr, a_mdout);
    end
    // abort in the middle of the preamble
    mrstn = 1'b0;
    #1;
    n_checks++;
    if ({a_ready, a_mcs, a_mwr, a_maddr, a_mdout, a_iocs, a_iowr, a_done, a_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_abort: got ready %b mcs %b maddr %h mdout %h, required all 0",
               a_ready, a_mcs, a_maddr, a_mdout);
    end
    m0 = mcs_cnt;
    s_valid = 1'b0;
    @(negedge mclk);
    mrstn = 1'b1;
    cycles(10);
    #1;
    n_checks++;
    if (mcs_cnt != m0 || done_cnt != 0 || exp_w.size() != 0) begin
      n_fail++;
      $display("FAIL reset_abort_quiet: got %0d new mcs, %0d done, %0d pending words, required 0 0 0",
               mcs_cnt - m0, done_cnt, exp_w.size());
    end
  endtask

  task automatic test_frame16(input bit gaps, input string name);
    int d0;
    sel = 1'b0;
    d0 = done_cnt;
    send_frame(16, 8'h00, gaps, 16, 20, name);
    wait_done(d0 + 1, name);
    pulse_busy();
    n_checks++;
    if (exp_w.size() != 0 || exp_c.size() != 0) begin
      n_fail++;
      $display("FAIL %s_complete: got %0d words and %0d commands missing, required 0 0",
               name, exp_w.size(), exp_c.size());
    end
  endtask

  task automatic test_pad();
    int d0;
    sel = 1'b1;
    d0 = done_cnt;
    send_frame(5, 8'hAA, 1'b0, 60, 1514, "pad");
    wait_done(d0 + 1, "pad");
    pulse_busy();
    n_checks++;
    if (exp_w.size() != 0 || exp_c.size() != 0) begin
      n_fail++;
      $display("FAIL pad_complete: got %0d words and %0d commands missing, required 0 0",
               exp_w.size(), exp_c.size());
    end
    sel = 1'b0;
  endtask

  task automatic test_oversize();
    int e0, a0, d0;
    sel = 1'b0;
    e0 = err_cnt; a0 = acc_cnt; d0 = done_cnt;
    send_frame(25, 8'h30, 1'b0, 16, 20, "oversize");
    cycles(6);
    #1;
    n_checks++;
    if (err_cnt != e0 + 1) begin
      n_fail++;
      $display("FAIL oversize_err_count: got %0d err pulses, required 1", err_cnt - e0);
    end
    n_checks++;
    if (err_at != a0 + 21) begin
      n_fail++;
      $display("FAIL oversize_err_byte: got err after %0d bytes, required after 21", err_at - a0);
    end
    n_checks++;
    if (done_cnt != d0 || exp_c.size() != 0 || exp_w.size() != 0) begin
      n_fail++;
      $display("FAIL oversize_no_cmd: got %0d done, %0d commands and %0d words pending, required 0 0 0",
               done_cnt - d0, exp_c.size(), exp_w.size());
    end
    n_checks++;
    if (a_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL oversize_idle: got s_ready %b, required 0", a_ready);
    end
  endtask

  task automatic test_back_to_back();
    int d0, m0;
    sel = 1'b0;
    d0 = done_cnt;
    send_frame(16, 8'h00, 1'b0, 16, 20, "b2b_first");
    wait_done(d0 + 1, "b2b_first");
    m0 = mcs_cnt;
    fork
      send_frame(16, 8'h40, 1'b0, 16, 20, "b2b_second");
      begin
        cycles(6);
        #1;
        n_checks++;
        if (mcs_cnt != m0) begin
          n_fail++;
          $display("FAIL b2b_hold_before_busy: got %0d buffer selects, required 0", mcs_cnt - m0);
        end
        tx_busy = 1'b1;
        cycles(4);
        #1;
        n_checks++;
        if (mcs_cnt != m0) begin
          n_fail++;
          $display("FAIL b2b_hold_during_busy: got %0d buffer selects, required 0", mcs_cnt - m0);
        end
        tx_busy = 1'b0;
      end
    join
    wait_done(d0 + 2, "b2b_second");
    pulse_busy();
    n_checks++;
    if (exp_w.size() != 0 || exp_c.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_complete: got %0d words and %0d commands missing, required 0 0",
               exp_w.size(), exp_c.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame16(1'b0, "frame16");
    test_pad();
    test_frame16(1'b1, "gaps16");
    test_oversize();
    test_back_to_back();
    n_checks++;
    if (both_cnt != 0) begin
      n_fail++;
      $display("FAIL mcs_iocs_exclusive: got %0d cycles with both high, required 0", both_cnt);
    end
    n_checks++;
    if (done_bad != 0) begin
      n_fail++;
      $display("FAIL done_with_cmd: got %0d done pulses outside the command cycle, required 0", done_bad);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/eth_tx_framer.md
Name: eth_tx_framer

Overview:
- Upstream feeder for the ethernet100 transmit path.
- Accepts a payload byte stream with a valid/ready/last handshake.
- Writes preamble, SFD and payload into the ethernet100 transmit buffer (mcs0/maddr/mwr0/min0 port), zero-padded to minimum frame size.
- Issues the transmit-start I/O write (ioaddr 1, din = total byte count), replacing host firmware doing the same sequence.

Parameters:
- AW, 10, transmit buffer word-address width.
- MIN_BYTES, 60, minimum payload bytes after padding (even).
- MAX_BYTES, 1514, maximum payload bytes accepted; must satisfy 8+MAX_BYTES <= 2^(AW+1).

Ports:
- mclk  in  1  system clock, all logic on rising edge.
- mrstn  in  1  asynchronous active-low reset.
- s_data  in  8  payload byte.
- s_valid  in  1  s_data valid.
- s_last  in  1  marks final payload byte; qualified by s_valid.
- s_ready  out  1  byte accepted when s_valid & s_ready.
- tx_busy  in  1  ethernet100 transmitter busy (status bit); buffer must not be written while high.
- mcs  out  1  buffer chip select (to mcs0).
- mwr  out  1  buffer write strobe (to mwr0).
- maddr  out  AW  buffer word address.
- mdout  out  16  buffer write data (to min0); low byte is first on wire.
- iocs  out  1  I/O select.
- iowr  out  1  I/O write strobe.
- ioaddr  out  3  I/O register address.
- iodout  out  16  I/O write data.
- done  out  1  one-cycle pulse, frame handed to transmitter.
- err  out  1  one-cycle pulse, oversize frame discarded.

Behaviour:
- Reset (async, mrstn low): state IDLE; all outputs 0, including s_ready, mcs, mwr, iocs, iowr, maddr, mdout, ioaddr, iodout, done, err; byte counter 0.
- All outputs registered.
- States: IDLE, PRE, DATA, PAD, CMD, WAITB, DROP.
- IDLE: s_ready=0. On s_valid & !tx_busy, go to PRE. s_valid while tx_busy=1 waits.
- PRE: 4 consecutive cycles writing addr 0..3 with 5555, 5555, 5555, 55D5 (mcs=mwr=1). Then DATA.
- DATA:
  - s_ready=1. Byte index n counts from 0.
  - Even n: byte held in low register; no write.
  - Odd n: next cycle writes word {byte, held} at addr 4+(n>>1).
  - s_last on even n: next cycle writes {8'h00, byte}.
  - On s_last: len = n+1, go to PAD if len < MIN_BYTES, else CMD.
  - Accepting byte index MAX_BYTES without s_last: err pulses, go to DROP.
- PAD: writes 0000 at the following word addresses, one per cycle, until addr 4+MIN_BYTES/2-1 has been written; len := MIN_BYTES. Then CMD.
- CMD:
  - One cycle: iocs=iowr=1, ioaddr=1, iodout = 8+len (includes preamble/SFD; odd len keeps odd count).
  - mcs=mwr=0 in this cycle.
  - done pulses the same cycle. Then WAITB.
- WAITB: s_ready=0; stay until tx_busy seen high, then low again (handles status synchronisation latency); then IDLE. A frame never starts while the previous one transmits.
- DROP: s_ready=1, bytes discarded until s_last accepted; then IDLE. No CMD issued; buffer contents undefined.
- s_valid low mid-frame: DATA holds; no write, counters frozen. No timeout.
- s_last on the very first byte: legal; len=1, padded to MIN_BYTES.
- mrstn asserted mid-frame: immediate abort. No command is issued. The partially written buffer is ignored.
- mcs and iocs never both high in one cycle. maddr/mdout hold last value when mwr=0.

Test Plan:
- Reset: hold mrstn low with s_valid=1 -> all outputs 0, s_ready 0; release -> PRE starts the next edge after tx_busy=0.
- 16-byte frame, bytes 00..0F, no gaps, MIN_BYTES=16:
  - addr 0..3 = 5555, 5555, 5555, 55D5.
  - addr 4..11 = 0100, 0302, …, 0F0E.
  - CMD ioaddr=1, iodout=24, done pulse.
- 5-byte frame AA..AE, MIN_BYTES=60:
  - addr 4..6 = ABAA, ADAC, 00AE.
  - addr 7..33 = 0000.
  - iodout=68.
- Valid gaps and backpressure: deassert s_valid every other byte on the 16-byte frame -> identical buffer contents; no write during gap cycles.
- Oversize (MAX_BYTES=20): send 25 bytes -> err pulse on byte 20, remaining accepted/dropped, no iocs/iowr, return to IDLE.
- Back-to-back frames: second frame valid immediately after done -> no mcs until tx_busy has risen and fallen; second frame is then written from addr 0.
